store_checker: RTL

Bus-side self-check stage directly downstream of the processor `top`. It consumes the processor's `memwrite`, `dataadr` and `writedata` outputs and compares every store against a pre-loaded list of expected (address, data) pairs. It reports a sticky pass/fail verdict, so the simulation bench and the FPGA build can both detect program completion without hard-coded address compares.

---
 rtl/store_checker_pkg.sv | 25 ++
 rtl/store_fifo.sv | 50 +++++
 rtl/store_checker.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/store_checker_pkg.sv
// Shared types for the store checker: FSM states, failure codes, store payload.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package store_checker_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISMATCH = 2'b01,
        FC_TIMEOUT  = 2'b10,
        FC_OVERFLOW = 2'b11
    } fail_code_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } store_t;

endpackage

// File: rtl/store_fifo.sv
// Generic capture FIFO for store_t payloads, DEPTH entries (power of two).
// Latency: pushed entry visible at the head on the cycle after the push edge.
// Backpressure: none upstream; a push while full is dropped unless a pop occurs the same cycle.
module store_fifo
    import store_checker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  store_t push_dat,
    input  logic   pop,
    output store_t pop_dat,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    store_t         mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // When full, the head is read out combinationally before the same slot is overwritten.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care while not covered by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/store_checker.sv
// Checks processor stores in order against a preloaded expected list; sticky pass/fail verdict.
// Latency: store pushed on edge E, popped on E+1, verdict on E+2; watchdog under STORE_CHECKER_WATCHDOG_EN.
// Backpressure: none possible upstream; FIFO overflow is reported as a failure (code 11).
module store_checker
    import store_checker_pkg::*;
#(
    parameter int NEXP    = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        load_valid,
    input  logic [31:0] load_adr,
    input  logic [31:0] load_data,
    input  logic        start,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [3:0]  fail_idx,
    output logic [7:0]  store_count
);

    localparam int CW = $clog2(NEXP + 1);
    localparam int IW = $clog2(NEXP);
    localparam logic [CW-1:0] NEXP_C = CW'(NEXP);

    state_t         state;
    state_t         state_nxt;
    fail_code_t     fc_nxt;

    store_t         entries [NEXP];
    logic [CW-1:0]  nexp;
    logic [CW-1:0]  ptr;
    logic [CW-1:0]  ptr_inc;
    logic           load_ok;

    logic           cmp_vld;
    store_t         cmp_act;
    store_t         cmp_exp;
    logic           cmp_match;
    logic           cmp_miss;

    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    store_t         pop_dat;
    logic           overflow;
    logic           wd_hit;

    assign load_ok   = (state == LOAD) && load_valid && (nexp != NEXP_C);
    assign push      = (state == RUN) && memwrite;
    assign pop       = (state == RUN) && !empty && !cmp_vld;
    assign overflow  = push && full && !pop;
    assign cmp_match = (state == RUN) && cmp_vld && (cmp_act == cmp_exp);
    assign cmp_miss  = (state == RUN) && cmp_vld && (cmp_act != cmp_exp);
    assign ptr_inc   = ptr + 1'b1;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({dataadr, writedata}),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (full),
        .empty    (empty)
    );

`ifdef STORE_CHECKER_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic [15:0] wd_nxt;

    assign wd_nxt = wd_cnt + 16'd1;
    // A matching compare in the same cycle counts as progress, so it suppresses the timeout.
    assign wd_hit = (state == RUN) && (wd_nxt == 16'(TIMEOUT)) && !cmp_match;

    // Watchdog: held at zero in LOAD (so start begins from zero), counts RUN cycles, cleared on match.
    always_ff @(posedge clk) begin
        if (reset || state == LOAD) wd_cnt <= '0;
        else if (state == RUN)      wd_cnt <= cmp_match ? 16'd0 : wd_nxt;
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Next-state logic; overflow outranks mismatch, which outranks timeout.
    always_comb begin
        state_nxt = state;
        fc_nxt    = FC_NONE;
        case (state)
            LOAD: begin
                if (start) state_nxt = (nexp == '0) ? PASS : RUN;
            end
            RUN: begin
                if (overflow) begin
                    state_nxt = FAIL;
                    fc_nxt    = FC_OVERFLOW;
                end else if (cmp_miss) begin
                    state_nxt = FAIL;
                    fc_nxt    = FC_MISMATCH;
                end else if (cmp_match && ptr_inc == nexp) begin
                    state_nxt = PASS;
                end else if (wd_hit) begin
                    state_nxt = FAIL;
                    fc_nxt    = FC_TIMEOUT;
                end
            end
            default: state_nxt = state;
        endcase
    end

    // State and registered verdict outputs; failure details are captured only on FAIL entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == PASS) || (state_nxt == FAIL);
            pass  <= (state_nxt == PASS);
            if (state == RUN && state_nxt == FAIL) begin
                fail_code <= fc_nxt;
                fail_idx  <= 4'(ptr);
            end
        end
    end

    // Expected-list fill count and compare stage (pop into register, resolve next edge).
    always_ff @(posedge clk) begin
        if (reset) begin
            nexp    <= '0;
            ptr     <= '0;
            cmp_vld <= 1'b0;
            cmp_act <= '0;
            cmp_exp <= '0;
        end else begin
            if (load_ok) nexp <= nexp + 1'b1;
            if (pop) begin
                cmp_vld <= 1'b1;
                cmp_act <= pop_dat;
                cmp_exp <= entries[ptr[IW-1:0]];
            end else if (cmp_match) begin
                cmp_vld <= 1'b0;
                ptr     <= ptr_inc;
            end
        end
    end

    // Expected entries; not reset because nexp = 0 invalidates them.
    always_ff @(posedge clk) begin
        if (load_ok) entries[nexp[IW-1:0]] <= {load_adr, load_data};
    end

    // Captured-store counter, saturating at 255, only advances in RUN.
    always_ff @(posedge clk) begin
        if (reset)                              store_count <= '0;
        else if (push && store_count != 8'hFF)  store_count <= store_count + 8'd1;
    end

endmodule
